alu_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared 32-bit ALU. Each requester presents an ALU operation and its two operands through a valid/ready handshake. The block grants one request at a time, drives the ALU from registered operands, and captures the result and zero flag. It returns them with a requester ID through a valid/ready response port. It sits between the ALU and its clients, for example the main execute path and an address/branch helper, so that one ALU instance can serve both.

---
 rtl/alu_arbiter_if.sv | 52 +++++
 rtl/alu_arbiter.sv | 144 ++++++++++++++
 tb/tb_alu_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, ALU and response signals of the shared-ALU arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the
// requesters, the ALU and the response consumer taken together.
interface alu_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req0_valid_i;
    logic                  req1_valid_i;
    logic                  req0_ready_o;
    logic                  req1_ready_o;
    logic [3:0]            req0_op_i;
    logic [3:0]            req1_op_i;
    logic [DATA_WIDTH-1:0] req0_a_i;
    logic [DATA_WIDTH-1:0] req0_b_i;
    logic [DATA_WIDTH-1:0] req1_a_i;
    logic [DATA_WIDTH-1:0] req1_b_i;

    logic [3:0]            alu_operation_o;
    logic [DATA_WIDTH-1:0] alu_a_o;
    logic [DATA_WIDTH-1:0] alu_b_o;
    logic [DATA_WIDTH-1:0] alu_data_i;
    logic                  alu_zero_i;

    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic                  rsp_id_o;
    logic [DATA_WIDTH-1:0] rsp_data_o;
    logic                  rsp_zero_o;
    logic                  rsp_err_o;

    modport slave (
        input  req0_valid_i, req1_valid_i,
        input  req0_op_i, req1_op_i,
        input  req0_a_i, req0_b_i, req1_a_i, req1_b_i,
        output req0_ready_o, req1_ready_o,
        output alu_operation_o, alu_a_o, alu_b_o,
        input  alu_data_i, alu_zero_i,
        output rsp_valid_o, rsp_id_o, rsp_data_o, rsp_zero_o, rsp_err_o,
        input  rsp_ready_i
    );

    modport master (
        output req0_valid_i, req1_valid_i,
        output req0_op_i, req1_op_i,
        output req0_a_i, req0_b_i, req1_a_i, req1_b_i,
        input  req0_ready_o, req1_ready_o,
        input  alu_operation_o, alu_a_o, alu_b_o,
        output alu_data_i, alu_zero_i,
        input  rsp_valid_o, rsp_id_o, rsp_data_o, rsp_zero_o, rsp_err_o,
        output rsp_ready_i
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin arbiter and sequencer for one shared ALU.
// Each accepted operation takes three cycles: IDLE (accept), EXEC (drive the ALU)
// and RESP (hold the result until the consumer takes it).
// Optional feature: define ALU_ARB_OPCHECK_EN to flag opcodes other than ADD/ORI.
// A flagged op is still accepted. The ALU then sees op 0, and the response returns
// err=1, data=0, zero=1.
module alu_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    alu_arbiter_if.slave  bus
);

    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_ORI = 4'b0001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state;
    state_t                next_state;
    logic                  last_grant;
    logic                  grant;
    logic                  accept;
    logic [3:0]            op_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic                  id_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_zero_q;
    logic [3:0]            exec_op;

`ifdef ALU_ARB_OPCHECK_EN
    logic                  op_err_q;
    logic                  rsp_err_q;
`endif

    // Pick the grantee: a lone requester wins, and on a tie the one not served last wins
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid_i && bus.req1_valid_i) begin
            grant = ~last_grant;
        end else if (bus.req1_valid_i) begin
            grant = 1'b1;
        end
    end

    assign accept = (state == IDLE) && (bus.req0_valid_i || bus.req1_valid_i);

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic for the accept / execute / respond sequence
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = EXEC;
            EXEC:    next_state = RESP;
            RESP:    if (bus.rsp_ready_i) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Latch the granted request at accept, then capture the ALU result during EXEC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
            op_err_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
`endif
        end else begin
            if (accept) begin
                last_grant <= grant;
                id_q       <= grant;
                op_q       <= grant ? bus.req1_op_i : bus.req0_op_i;
                a_q        <= grant ? bus.req1_a_i  : bus.req0_a_i;
                b_q        <= grant ? bus.req1_b_i  : bus.req0_b_i;
`ifdef ALU_ARB_OPCHECK_EN
                op_err_q   <= !(((grant ? bus.req1_op_i : bus.req0_op_i) == OP_ADD) ||
                                ((grant ? bus.req1_op_i : bus.req0_op_i) == OP_ORI));
`endif
            end
            if (state == EXEC) begin
`ifdef ALU_ARB_OPCHECK_EN
                if (op_err_q) begin
                    rsp_data_q <= '0;
                    rsp_zero_q <= 1'b1;
                    rsp_err_q  <= 1'b1;
                end else begin
                    rsp_data_q <= bus.alu_data_i;
                    rsp_zero_q <= bus.alu_zero_i;
                    rsp_err_q  <= 1'b0;
                end
`else
                rsp_data_q <= bus.alu_data_i;
                rsp_zero_q <= bus.alu_zero_i;
`endif
            end
        end
    end

`ifdef ALU_ARB_OPCHECK_EN
    assign exec_op = op_err_q ? 4'b0000 : op_q;
`else
    assign exec_op = op_q;
`endif

    // Outputs decoded from state: ready only in IDLE, ALU op only in EXEC, response valid in RESP
    always_comb begin
        bus.req0_ready_o    = accept && !grant;
        bus.req1_ready_o    = accept && grant;
        bus.alu_operation_o = (state == EXEC) ? exec_op : 4'b0000;
        bus.rsp_valid_o     = (state == RESP);
    end

    assign bus.alu_a_o    = a_q;
    assign bus.alu_b_o    = b_q;
    assign bus.rsp_id_o   = id_q;
    assign bus.rsp_data_o = rsp_data_q;
    assign bus.rsp_zero_o = rsp_zero_q;
`ifdef ALU_ARB_OPCHECK_EN
    assign bus.rsp_err_o  = rsp_err_q;
`else
    assign bus.rsp_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed, table-driven bench for alu_arbiter.
// A small ALU model (ADD, ORI, anything else gives 0) closes the loop on the ALU port.
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam logic [3:0] ADD = 4'b0011;
    localparam logic [3:0] ORI = 4'b0001;
    localparam logic [3:0] ILL = 4'b0110;
`ifdef ALU_ARB_OPCHECK_EN
    localparam logic [3:0] ILL_ALU_OP = 4'b0000;
    localparam logic       ILL_ERR    = 1'b1;
`else
    localparam logic [3:0] ILL_ALU_OP = ILL;
    localparam logic       ILL_ERR    = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic [DW-1:0] alu_result;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    alu_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference ALU: combinational from the arbiter's ALU outputs
    always_comb begin
        case (bus.alu_operation_o)
            ADD:     alu_result = bus.alu_a_o + bus.alu_b_o;
            ORI:     alu_result = bus.alu_a_o | bus.alu_b_o;
            default: alu_result = '0;
        endcase
    end
    assign bus.alu_data_i = alu_result;
    assign bus.alu_zero_i = (alu_result == '0);

    typedef struct {
        bit         v0;
        bit         v1;
        logic [3:0] op0;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [3:0] op1;
        logic [31:0] a1;
        logic [31:0] b1;
        bit         hold;
        int         stall;
        bit         exp_id;
        logic [3:0] exp_alu_op;
        logic [31:0] exp_data;
        bit         exp_zero;
        bit         exp_err;
    } vec_t;

    vec_t main_vecs[7];
    vec_t tie_vecs[5];

    function automatic vec_t mk(bit v0, bit v1,
                                logic [3:0] op0, logic [31:0] a0, logic [31:0] b0,
                                logic [3:0] op1, logic [31:0] a1, logic [31:0] b1,
                                bit hold, int stall, bit exp_id, logic [3:0] exp_alu_op,
                                logic [31:0] exp_data, bit exp_zero, bit exp_err);
        vec_t v;
        v.v0 = v0; v.v1 = v1;
        v.op0 = op0; v.a0 = a0; v.b0 = b0;
        v.op1 = op1; v.a1 = a1; v.b1 = b1;
        v.hold = hold; v.stall = stall;
        v.exp_id = exp_id; v.exp_alu_op = exp_alu_op;
        v.exp_data = exp_data; v.exp_zero = exp_zero; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.req0_valid_i = v.v0;
        bus.req1_valid_i = v.v1;
        bus.req0_op_i    = v.op0;
        bus.req0_a_i     = v.a0;
        bus.req0_b_i     = v.b0;
        bus.req1_op_i    = v.op1;
        bus.req1_a_i     = v.a1;
        bus.req1_b_i     = v.b1;
        bus.rsp_ready_i  = (v.stall == 0);
    endtask

    // Runs one transaction from an IDLE negedge back to the next IDLE negedge
    task automatic runVector(input vec_t v, input string tag);
        logic [31:0] ga;
        logic [31:0] gb;
        ga = v.exp_id ? v.a1 : v.a0;
        gb = v.exp_id ? v.b1 : v.b0;
        applyStimulus(v);
        #1;
        checkOutput({tag, " idle ready0"}, 32'(bus.req0_ready_o), 32'(!v.exp_id));
        checkOutput({tag, " idle ready1"}, 32'(bus.req1_ready_o), 32'(v.exp_id));
        checkOutput({tag, " idle rsp_valid"}, 32'(bus.rsp_valid_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        if (!v.hold) begin
            if (v.exp_id) bus.req1_valid_i = 1'b0;
            else          bus.req0_valid_i = 1'b0;
        end
        #1;
        checkOutput({tag, " exec alu_op"}, 32'(bus.alu_operation_o), 32'(v.exp_alu_op));
        checkOutput({tag, " exec alu_a"}, bus.alu_a_o, ga);
        checkOutput({tag, " exec alu_b"}, bus.alu_b_o, gb);
        checkOutput({tag, " exec rsp_valid"}, 32'(bus.rsp_valid_o), 32'd0);
        checkOutput({tag, " exec readys"}, 32'({bus.req1_ready_o, bus.req0_ready_o}), 32'd0);
        @(negedge clk);
        for (int i = 0; i < v.stall; i++) begin
            #1;
            checkOutput($sformatf("%s stall%0d rsp_valid", tag, i), 32'(bus.rsp_valid_o), 32'd1);
            checkOutput($sformatf("%s stall%0d rsp_data", tag, i), bus.rsp_data_o, v.exp_data);
            checkOutput($sformatf("%s stall%0d readys", tag, i),
                        32'({bus.req1_ready_o, bus.req0_ready_o}), 32'd0);
            @(negedge clk);
        end
        bus.rsp_ready_i = 1'b1;
        #1;
        checkOutput({tag, " rsp_valid"}, 32'(bus.rsp_valid_o), 32'd1);
        checkOutput({tag, " rsp_id"}, 32'(bus.rsp_id_o), 32'(v.exp_id));
        checkOutput({tag, " rsp_data"}, bus.rsp_data_o, v.exp_data);
        checkOutput({tag, " rsp_zero"}, 32'(bus.rsp_zero_o), 32'(v.exp_zero));
        checkOutput({tag, " rsp_err"}, 32'(bus.rsp_err_o), 32'(v.exp_err));
        checkOutput({tag, " resp readys"}, 32'({bus.req1_ready_o, bus.req0_ready_o}), 32'd0);
        checkOutput({tag, " resp alu_op"}, 32'(bus.alu_operation_o), 32'd0);
        @(negedge clk);
        #1;
        checkOutput({tag, " back idle rsp_valid"}, 32'(bus.rsp_valid_o), 32'd0);
        checkOutput({tag, " back idle alu_op"}, 32'(bus.alu_operation_o), 32'd0);
    endtask

    // Directed sequence: reset values, table vectors, reset mid-operation, contention
    initial begin
        main_vecs[0] = mk(1, 0, ADD, 32'd5, 32'd7, 4'd0, 32'd0, 32'd0,
                          0, 0, 0, ADD, 32'd12, 0, 0);
        main_vecs[1] = mk(0, 1, 4'd0, 32'd0, 32'd0, ORI, 32'd0, 32'd0,
                          0, 0, 1, ORI, 32'd0, 1, 0);
        main_vecs[2] = mk(1, 0, ADD, 32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0, 32'd0,
                          0, 0, 0, ADD, 32'd0, 1, 0);
        main_vecs[3] = mk(0, 1, 4'd0, 32'd0, 32'd0, ORI, 32'hF0, 32'h0F,
                          0, 0, 1, ORI, 32'hFF, 0, 0);
        main_vecs[4] = mk(1, 0, ILL, 32'd3, 32'd3, 4'd0, 32'd0, 32'd0,
                          0, 0, 0, ILL_ALU_OP, 32'd0, 1, ILL_ERR);
        main_vecs[5] = mk(1, 1, ORI, 32'h12, 32'h21, ADD, 32'd100, 32'd23,
                          0, 5, 1, ADD, 32'd123, 0, 0);
        main_vecs[6] = mk(1, 0, ORI, 32'h12, 32'h21, 4'd0, 32'd0, 32'd0,
                          0, 0, 0, ORI, 32'h33, 0, 0);

        tie_vecs[0] = mk(1, 1, ADD, 32'd1, 32'd2, ORI, 32'hF0, 32'h0F, 1, 0, 0, ADD, 32'd3, 0, 0);
        tie_vecs[1] = mk(1, 1, ADD, 32'd1, 32'd2, ORI, 32'hF0, 32'h0F, 1, 0, 1, ORI, 32'hFF, 0, 0);
        tie_vecs[2] = mk(1, 1, ADD, 32'd1, 32'd2, ORI, 32'hF0, 32'h0F, 1, 0, 0, ADD, 32'd3, 0, 0);
        tie_vecs[3] = mk(1, 1, ADD, 32'd1, 32'd2, ORI, 32'hF0, 32'h0F, 0, 0, 1, ORI, 32'hFF, 0, 0);
        tie_vecs[4] = mk(1, 0, ADD, 32'd1, 32'd2, ORI, 32'hF0, 32'h0F, 0, 0, 0, ADD, 32'd3, 0, 0);

        reset            = 1'b1;
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        bus.req0_op_i    = '0;
        bus.req1_op_i    = '0;
        bus.req0_a_i     = '0;
        bus.req0_b_i     = '0;
        bus.req1_a_i     = '0;
        bus.req1_b_i     = '0;
        bus.rsp_ready_i  = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        checkOutput("reset rsp_id", 32'(bus.rsp_id_o), 32'd0);
        checkOutput("reset rsp_data", bus.rsp_data_o, 32'd0);
        checkOutput("reset rsp_zero", 32'(bus.rsp_zero_o), 32'd0);
        checkOutput("reset rsp_err", 32'(bus.rsp_err_o), 32'd0);
        checkOutput("reset alu_op", 32'(bus.alu_operation_o), 32'd0);
        checkOutput("reset alu_a", bus.alu_a_o, 32'd0);
        checkOutput("reset alu_b", bus.alu_b_o, 32'd0);
        checkOutput("reset readys", 32'({bus.req1_ready_o, bus.req0_ready_o}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            runVector(main_vecs[i], $sformatf("vec%0d", i));
        end

        // Abort an ADD of 0x10 + 0x20 while it is in EXEC
        bus.req0_valid_i = 1'b1;
        bus.req0_op_i    = ADD;
        bus.req0_a_i     = 32'h10;
        bus.req0_b_i     = 32'h20;
        bus.req1_valid_i = 1'b0;
        bus.rsp_ready_i  = 1'b1;
        #1;
        checkOutput("abort ready0", 32'(bus.req0_ready_o), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req0_valid_i = 1'b0;
        #1;
        checkOutput("abort exec alu_op", 32'(bus.alu_operation_o), 32'(ADD));
        reset = 1'b1;
        #1;
        checkOutput("abort rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        checkOutput("abort alu_op", 32'(bus.alu_operation_o), 32'd0);
        checkOutput("abort alu_a", bus.alu_a_o, 32'd0);
        checkOutput("abort alu_b", bus.alu_b_o, 32'd0);
        checkOutput("abort rsp_data", bus.rsp_data_o, 32'd0);
        checkOutput("abort rsp_id", 32'(bus.rsp_id_o), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("abort quiet%0d rsp_valid", i), 32'(bus.rsp_valid_o), 32'd0);
        end

        for (int i = 0; i < 5; i++) begin
            runVector(tie_vecs[i], $sformatf("tie%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
